// File: rtl/reg_file_pkg.sv
// Shared types and sizes for the architectural register file.
// XLEN, ROB tag width, register count and the id/tag/word typedefs.
package reg_file_pkg;

    localparam int XLEN           = 32;
    localparam int ROB_ID_WIDTH   = 4;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_id_t;
    typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
    typedef logic [XLEN-1:0]           word_t;

endpackage

// File: rtl/reg_file_if.sv
// Decoder/ROB-facing bus of the register file: rollback, rename,
// two source queries and the ROB register-commit channel.
// master = decoder/ROB side, slave = reg_file.
interface reg_file_if;
    import reg_file_pkg::*;

    logic    rollback;

    logic    rename_config;
    reg_id_t rename_rd;
    rob_id_t rename_rob;

    reg_id_t rs1_id;
    logic    rs1_busy;
    rob_id_t rs1_tag;
    word_t   rs1_value;

    reg_id_t rs2_id;
    logic    rs2_busy;
    rob_id_t rs2_tag;
    word_t   rs2_value;

    logic    commit_reg_config;
    reg_id_t commit_reg_id;
    word_t   commit_reg_value;
    rob_id_t commit_reg_rob;

    modport master (
        output rollback,
        output rename_config, rename_rd, rename_rob,
        output rs1_id, rs2_id,
        output commit_reg_config, commit_reg_id,
        output commit_reg_value, commit_reg_rob,
        input  rs1_busy, rs1_tag, rs1_value,
        input  rs2_busy, rs2_tag, rs2_value
    );

    modport slave (
        input  rollback,
        input  rename_config, rename_rd, rename_rob,
        input  rs1_id, rs2_id,
        input  commit_reg_config, commit_reg_id,
        input  commit_reg_value, commit_reg_rob,
        output rs1_busy, rs1_tag, rs1_value,
        output rs2_busy, rs2_tag, rs2_value
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One source-operand lookup: x0 handling plus optional commit bypass.
// Ports: id in; busy/tag/value state vectors in; commit channel in;
// busy/tag/value out. Bypass compiled in with REGFILE_BYPASS_EN.
module reg_file_read_port
    import reg_file_pkg::*;
(
    input  reg_id_t                    id,
    input  logic    [NUM_REGS-1:0]     busy_vec,
    input  rob_id_t [NUM_REGS-1:0]     tag_vec,
    input  word_t   [NUM_REGS-1:0]     value_vec,
    input  logic                       commit_en,
    input  reg_id_t                    commit_id,
    input  rob_id_t                    commit_rob,
    input  word_t                      commit_value,
    output logic                       busy,
    output rob_id_t                    tag,
    output word_t                      value
);

    logic hit;

`ifdef REGFILE_BYPASS_EN
    // commit_en already excludes x0, so a hit implies id != 0
    assign hit = commit_en
              && (commit_id == id)
              && busy_vec[id]
              && (tag_vec[id] == commit_rob);
`else
    logic unused_bypass;
    assign unused_bypass = ^{commit_en, commit_id, commit_rob};
    assign hit = 1'b0;
`endif

    always_comb begin
        busy  = 1'b0;
        tag   = '0;
        value = '0;
        if (id != '0) begin
            busy  = busy_vec[id] && !hit;
            tag   = tag_vec[id];
            value = hit ? commit_value : value_vec[id];
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file x0-x31 with per-register busy flag and
// ROB tag. Ports: clk, rst (async active-low), rdy (global enable),
// bus (reg_file_if.slave). Optional macro: REGFILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    reg_file_if.slave   bus
);

    logic    [NUM_REGS-1:0] busy_q;
    rob_id_t [NUM_REGS-1:0] tag_q;
    word_t   [NUM_REGS-1:0] value_q;

    logic commit_en;
    logic rename_en;
    logic commit_clear;

    assign commit_en = rdy
                    && bus.commit_reg_config
                    && (bus.commit_reg_id != '0);

    // a rollback drops the rename issued alongside it
    assign rename_en = rdy
                    && bus.rename_config
                    && (bus.rename_rd != '0)
                    && !bus.rollback;

    // exact tag match keeps a stale commit from freeing a newer rename
    assign commit_clear = commit_en
                       && busy_q[bus.commit_reg_id]
                       && (tag_q[bus.commit_reg_id] == bus.commit_reg_rob)
                       && !(rename_en
                            && (bus.rename_rd == bus.commit_reg_id));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= '0;
            tag_q   <= '0;
            value_q <= '0;
        end else if (rdy) begin
            if (commit_en) begin
                value_q[bus.commit_reg_id] <= bus.commit_reg_value;
            end
            if (bus.rollback) begin
                busy_q <= '0;
                tag_q  <= '0;
            end else begin
                if (commit_clear) begin
                    busy_q[bus.commit_reg_id] <= 1'b0;
                end
                if (rename_en) begin
                    busy_q[bus.rename_rd] <= 1'b1;
                    tag_q[bus.rename_rd]  <= bus.rename_rob;
                end
            end
        end
    end

    reg_file_read_port u_rs1 (
        .id           (bus.rs1_id),
        .busy_vec     (busy_q),
        .tag_vec      (tag_q),
        .value_vec    (value_q),
        .commit_en    (commit_en),
        .commit_id    (bus.commit_reg_id),
        .commit_rob   (bus.commit_reg_rob),
        .commit_value (bus.commit_reg_value),
        .busy         (bus.rs1_busy),
        .tag          (bus.rs1_tag),
        .value        (bus.rs1_value)
    );

    reg_file_read_port u_rs2 (
        .id           (bus.rs2_id),
        .busy_vec     (busy_q),
        .tag_vec      (tag_q),
        .value_vec    (value_q),
        .commit_en    (commit_en),
        .commit_id    (bus.commit_reg_id),
        .commit_rob   (bus.commit_reg_rob),
        .commit_value (bus.commit_reg_value),
        .busy         (bus.rs2_busy),
        .tag          (bus.rs2_tag),
        .value        (bus.rs2_value)
    );

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename status for the out-of-order core. It holds x0–x31 and a per-register busy flag and ROB tag. It is the receiving end of the ROB's register-commit interface, takes rename requests from the decoder, and answers the decoder's two source-operand queries. On rollback it discards all in-flight rename state.

## Interface
- XLEN, 32, data width
- ROB_ID_WIDTH, 4, ROB entry tag width (16 entries)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, all state holds and commits/renames are ignored
- rollback  in  1  flush all rename state
- rename_config  in  1  decoder issued an instruction with a destination this cycle
- rename_rd  in  5  destination register
- rename_rob  in  ROB_ID_WIDTH  ROB entry allocated to that instruction
- rs1_id, rs2_id  in  5  source register queries
- rs1_busy, rs2_busy  out  1  source awaits an uncommitted producer
- rs1_tag, rs2_tag  out  ROB_ID_WIDTH  producer ROB entry (valid when busy)
- rs1_value, rs2_value  out  XLEN  architectural value (valid when not busy)
- commit_reg_config  in  1  ROB commits a register write this cycle
- commit_reg_id  in  5  committed destination
- commit_reg_value  in  XLEN  committed value
- commit_reg_rob  in  ROB_ID_WIDTH  ROB entry being committed

## Operation
- State: value[32], busy[32], tag[32]. Register x0 is hardwired: commits and renames to x0 are ignored. A query of x0 returns busy=0, tag=0, value=0.
- Commit (rdy=1, commit_reg_config=1, id≠0):
  - value[id] is always written.
  - busy[id] is cleared only if busy[id]=1, tag[id]==commit_reg_rob, and there is no same-cycle rename of id.
- Rename (rdy=1, rename_config=1, rd≠0, rollback=0): busy[rd]<=1 and tag[rd]<=rename_rob.
- Rename and commit to the same register in the same cycle: the rename wins busy/tag, and the commit still writes the value.
- Rollback (rdy=1): every busy<=0 and every tag<=0. Values are retained. A same-cycle commit still writes its value. A same-cycle rename is dropped.
- Queries are combinational from the registered state.
  - With bypass enabled (see Configuration), a same-cycle commit matching the query is forwarded. Match conditions: id equal, id≠0, busy[id]=1, tag[id]==commit_reg_rob.
  - On a match, the output shows busy=0 and value=commit_reg_value.
- Queries never reflect a same-cycle rename. Sources are read before the instruction's own rename.

## Timing
- Asynchronous reset: all values, busy, and tags are 0. Query outputs are therefore 0/0/0 during reset.
- Commit and rename take effect at the next rising edge. Query latency is 0 cycles (combinational).
- rdy low: no state change on that edge, regardless of the other inputs.
- A reset deasserted mid-stream clears all in-flight renames. Consumers rely on the ROB resetting alongside.
- A tag wrap-around (reuse of ROB entry 0..15) is safe because clearing requires an exact tag match.

## Configuration
- REGFILE_BYPASS_EN defined: commit-to-query forwarding is compiled in, as described in Operation.
- REGFILE_BYPASS_EN undefined: queries see registered state only. A register committed this cycle still reads busy=1 with the old tag until the next edge. The decoder then resolves the operand via the ROB value query.

## Structure
- Shared package contents: XLEN, ROB_ID_WIDTH, REG_ADDR_WIDTH=5, NUM_REGS=32, and typedefs reg_id_t, rob_id_t, word_t.
- Sub-module reg_file_read_port holds the per-source lookup, the x0 handling, and the bypass mux. It is instantiated twice (rs1, rs2).

## Test plan
- Reset, then query x5 -> busy=0, tag=0, value=0. Commit x0=0xDEAD -> later query of x0 returns 0.
- Rename x3→rob 7; next cycle query x3 -> busy=1, tag=7. Commit x3=0x1234 with rob 7 -> next cycle busy=0, value=0x1234.
- Rename x3→7, then rename x3→9, then commit x3 rob 7 value 0x55 -> value=0x55, busy stays 1, tag=9.
- Same cycle: rename x4→2 and commit x4 rob 1 (busy with tag 1) -> next cycle busy=1, tag=2, value=commit value.
- With x6 busy tag 5 and a same-cycle commit x6 rob 5 value 0xAB, query rs1=x6:
  - bypass enabled -> busy=0, value=0xAB in the same cycle.
  - bypass disabled -> busy=1, tag=5.
- Rename x1→3 and x2→4, then rollback together with a rename x7→6 -> all busy=0, x7 not busy, values unchanged. Repeat with rdy=0 -> no change.
